// File: rtl/midi_syx_tx.sv
// midi_syx_tx: outbound MIDI transmitter.
// Sends a SysEx patch dump as 8N1 UART at MIDI baud: F0, MFR_ID, channel byte,
// NUM_PARAMS parameter bytes read from patch RAM (masked to 7 bits), optional
// checksum, F7. Single pass-through bytes are accepted on a valid/ready
// handshake whenever the transmitter is idle. The bytes of a dump are sent
// back to back, with no gaps between them.
// Optional feature: define SYX_CHECKSUM_EN to insert the two's-complement
// checksum byte ahead of F7. Without it the frame is NUM_PARAMS+4 bytes.
module midi_syx_tx #(
    parameter int          BAUD_DIV   = 1600,
    parameter int          NUM_PARAMS = 128,
    parameter logic [7:0]  MFR_ID     = 8'h7D,
    parameter int          AW         = $clog2(NUM_PARAMS)
) (
    input  logic          reg_clk,
    input  logic          reset_reg_N,
    input  logic          dump_req,
    input  logic [3:0]    midi_ch,
    output logic [AW-1:0] param_addr,
    output logic          param_rd,
    input  logic [7:0]    param_data,
    input  logic [7:0]    tx_byte,
    input  logic          tx_byte_valid,
    output logic          tx_byte_ready,
    output logic          midi_txd,
    output logic          busy,
    output logic          byte_sent,
    output logic          dump_done
);

    localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_TOP  = BW'(BAUD_DIV - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PARAMS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        DATA,
`ifdef SYX_CHECKSUM_EN
        CSUM,
`endif
        EOX,
        SINGLE
    } state_t;

    state_t        state, next_state;

    // Serializer state
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          ser_active;

    // FSM -> serializer / datapath controls
    logic          load;
    logic [7:0]    load_data;
    logic          data_load;
    logic          dump_start;

    // Dump datapath
    logic [3:0]    ch_reg;
    logic [7:0]    data_reg;
    logic          rd_pend;
    logic          rd_done;
    logic [AW-1:0] data_idx;
`ifdef SYX_CHECKSUM_EN
    logic [6:0]    sum;
    logic [6:0]    csum;

    assign csum = ~sum + 7'd1;
`endif

    // byte_sent marks the last cycle of the stop bit; the FSM reloads in that
    // same cycle so the next start bit follows without a gap.
    assign byte_sent     = ser_active && (baud_cnt == '0) && (bit_cnt == 4'd9);
    assign dump_done     = byte_sent && (state == EOX);
    assign tx_byte_ready = (state == IDLE) && !dump_req;

    // Serializer: start bit, 8 data bits LSB first, stop bit; each BAUD_DIV cycles.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot change the result.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            ser_active <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            midi_txd   <= 1'b1;
        end else if (load) begin
            ser_active <= 1'b1;
            baud_cnt   <= BAUD_TOP;
            bit_cnt    <= '0;
            shreg      <= load_data;
            midi_txd   <= 1'b0;
        end else if (ser_active) begin
            if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else if (bit_cnt == 4'd9) begin
                ser_active <= 1'b0;
            end else begin
                baud_cnt <= BAUD_TOP;
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt < 4'd8) begin
                    midi_txd <= shreg[0];
                    shreg    <= {1'b0, shreg[7:1]};
                end else begin
                    midi_txd <= 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, serializer loads and prefetch strobes
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_data  = 8'h00;
        param_rd   = 1'b0;
        data_load  = 1'b0;
        dump_start = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    next_state = HDR0;
                    load       = 1'b1;
                    load_data  = 8'hF0;
                    dump_start = 1'b1;
                end else if (tx_byte_valid && tx_byte_ready) begin
                    next_state = SINGLE;
                    load       = 1'b1;
                    load_data  = tx_byte;
                end
            end
            HDR0: begin
                if (byte_sent) begin
                    next_state = HDR1;
                    load       = 1'b1;
                    load_data  = MFR_ID;
                end
            end
            HDR1: begin
                // Parameter 0 is fetched while the channel byte goes out.
                if (byte_sent) begin
                    next_state = HDR2;
                    load       = 1'b1;
                    load_data  = {4'h0, ch_reg};
                    param_rd   = !rd_done;
                end
            end
            HDR2: begin
                if (byte_sent) begin
                    next_state = DATA;
                    load       = 1'b1;
                    load_data  = data_reg & 8'h7F;
                    data_load  = 1'b1;
                    param_rd   = !rd_done;
                end
            end
            DATA: begin
                if (byte_sent) begin
                    load = 1'b1;
                    if (data_idx == LAST_ADDR) begin
`ifdef SYX_CHECKSUM_EN
                        next_state = CSUM;
                        load_data  = {1'b0, csum};
`else
                        next_state = EOX;
                        load_data  = 8'hF7;
`endif
                    end else begin
                        load_data = data_reg & 8'h7F;
                        data_load = 1'b1;
                        param_rd  = !rd_done;
                    end
                end
            end
`ifdef SYX_CHECKSUM_EN
            CSUM: begin
                if (byte_sent) begin
                    next_state = EOX;
                    load       = 1'b1;
                    load_data  = 8'hF7;
                end
            end
`endif
            EOX: begin
                if (byte_sent) next_state = IDLE;
            end
            SINGLE: begin
                if (byte_sent) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Dump datapath: channel latch, prefetch address/data, data index, checksum, busy
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            ch_reg     <= '0;
            data_reg   <= '0;
            rd_pend    <= 1'b0;
            rd_done    <= 1'b0;
            param_addr <= '0;
            data_idx   <= '0;
            busy       <= 1'b0;
`ifdef SYX_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            busy    <= (next_state != IDLE);
            rd_pend <= param_rd;
            if (rd_pend) data_reg <= param_data;

            if (dump_start) ch_reg <= midi_ch;

            // Address advances after each read and parks on the last one,
            // so it only moves when a read is issued.
            if (next_state == IDLE) begin
                param_addr <= '0;
                rd_done    <= 1'b0;
            end else if (param_rd) begin
                if (param_addr == LAST_ADDR) rd_done <= 1'b1;
                else                         param_addr <= param_addr + 1'b1;
            end

            if (dump_start)                        data_idx <= '0;
            else if (data_load && state == DATA)   data_idx <= data_idx + 1'b1;

`ifdef SYX_CHECKSUM_EN
            if (dump_start)     sum <= '0;
            else if (data_load) sum <= sum + load_data[6:0];
`endif
        end
    end

endmodule
